// File: rtl/ldm_stm_seq_if.sv
// Bundle of command, memory-bus and register-file port signals for the LDM/STM sequencer.
// The sequencer takes the master view; the environment (pipeline, memory, register file) takes the slave view.
interface ldm_stm_seq_if #(
   parameter int DW = 32
);
   logic          start;
   logic          load;
   logic          up;
   logic          pre;
   logic          wback;
   logic [3:0]    rn;
   logic [15:0]   reglist;
   logic [DW-1:0] base;
   logic          busy;
   logic          done;
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [3:0]    rf_ra;
   logic [DW-1:0] rf_rd;
   logic [3:0]    rf_wa;
   logic          rf_we;
   logic [DW-1:0] rf_wd;
   logic          pc_write;

   modport master (
      input  start, load, up, pre, wback, rn, reglist, base,
      input  mem_rdata, mem_ready, rf_rd,
      output busy, done, mem_req, mem_we, mem_addr, mem_wdata,
      output rf_ra, rf_wa, rf_we, rf_wd, pc_write
   );

   modport slave (
      output start, load, up, pre, wback, rn, reglist, base,
      output mem_rdata, mem_ready, rf_rd,
      input  busy, done, mem_req, mem_we, mem_addr, mem_wdata,
      input  rf_ra, rf_wa, rf_we, rf_wd, pc_write
   );
endinterface

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list low-to-high, one memory access
// per register, then an optional base-writeback cycle on the single register-file write port.
module ldm_stm_seq #(
   parameter int DW = 32
) (
   input  logic           clk,
   input  logic           reset_n,
   ldm_stm_seq_if.master  bus
);

   localparam logic [DW-1:0] STRIDE = DW'(DW / 8);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_WB   = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        r_state;
   logic          r_load;
   logic          r_wback;
   logic [3:0]    r_rn;
   logic [15:0]   r_list;
   logic [15:0]   r_pend;
   logic [DW-1:0] r_addr;
   logic [DW-1:0] r_newbase;
   logic          r_busy;
   logic          r_done;
   logic          r_mem_req;
   logic          r_mem_we;

   logic [4:0]    w_n;
   logic [DW-1:0] w_span;
   logic [DW-1:0] w_start_addr;
   logic [DW-1:0] w_newbase;
   logic [3:0]    w_cur;
   logic [15:0]   w_pend_next;
   logic          w_wb_en;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] cnt;
      cnt = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + {4'd0, v[i]};
      end
      return cnt;
   endfunction

   function automatic logic [3:0] lowest_bit(input logic [15:0] v);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

   assign w_n         = popcount16(bus.reglist);
   assign w_span      = DW'(w_n) * STRIDE;
   assign w_newbase   = bus.up ? (bus.base + w_span) : (bus.base - w_span);
   assign w_cur       = lowest_bit(r_pend);
   assign w_pend_next = r_pend & ~(16'd1 << w_cur);
   // A loaded base wins over writeback; R15 is never a writeback target.
   assign w_wb_en     = !(r_load && r_list[r_rn]) && (r_rn != 4'd15);

   // Lowest address of the block; accesses always ascend from here.
   always_comb begin
      w_start_addr = bus.base;
      case ({bus.up, bus.pre})
         2'b10:   w_start_addr = bus.base;
         2'b11:   w_start_addr = bus.base + STRIDE;
         2'b00:   w_start_addr = bus.base - w_span + STRIDE;
         2'b01:   w_start_addr = bus.base - w_span;
         default: w_start_addr = bus.base;
      endcase
   end

   // Sequencer FSM with registered status and memory-request outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_load    <= 1'b0;
         r_wback   <= 1'b0;
         r_rn      <= 4'd0;
         r_list    <= 16'd0;
         r_pend    <= 16'd0;
         r_addr    <= '0;
         r_newbase <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_load    <= bus.load;
                  r_wback   <= bus.wback;
                  r_rn      <= bus.rn;
                  r_list    <= bus.reglist;
                  r_pend    <= bus.reglist;
                  r_addr    <= w_start_addr;
                  r_newbase <= w_newbase;
                  r_busy    <= 1'b1;
                  if (w_n == 5'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state   <= S_XFER;
                     r_mem_req <= 1'b1;
                     r_mem_we  <= !bus.load;
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_XFER: begin
               if (bus.mem_ready) begin
                  r_pend <= w_pend_next;
                  r_addr <= r_addr + STRIDE;
                  if (w_pend_next == 16'd0) begin
                     r_mem_req <= 1'b0;
                     r_mem_we  <= 1'b0;
                     if (r_wback) begin
                        r_state <= S_WB;
                     end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                     end
                  end else begin
                     r_state <= S_XFER;
                  end
               end else begin
                  r_state <= S_XFER;
               end
            end
            S_WB: begin
               r_state <= S_DONE;
               r_done  <= 1'b1;
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state   <= S_IDLE;
               r_done    <= 1'b0;
               r_busy    <= 1'b0;
               r_mem_req <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.mem_req  = r_mem_req;
   assign bus.mem_we   = r_mem_we;
   assign bus.mem_addr = r_addr;

   // Register-file port: store source select, and load/writeback write port in the completing cycle.
   always_comb begin
      bus.rf_ra     = 4'd0;
      bus.mem_wdata = '0;
      bus.rf_wa     = 4'd0;
      bus.rf_we     = 1'b0;
      bus.rf_wd     = '0;
      bus.pc_write  = 1'b0;
      case (r_state)
         S_XFER: begin
            if (!r_load) begin
               bus.rf_ra     = w_cur;
               bus.mem_wdata = bus.rf_rd;
            end else if (bus.mem_ready) begin
               bus.rf_wd = bus.mem_rdata;
               if (w_cur == 4'd15) begin
                  bus.pc_write = 1'b1;
               end else begin
                  bus.rf_we = 1'b1;
                  bus.rf_wa = w_cur;
               end
            end else begin
               bus.rf_we = 1'b0;
            end
         end
         S_WB: begin
            bus.rf_wa = r_rn;
            bus.rf_wd = r_newbase;
            bus.rf_we = w_wb_en;
         end
         default: begin
            bus.rf_we = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: a spec-level model queues the expected access/writeback/done
// events at launch; an independent monitor pops and compares whenever the DUT presents one.
module tb_ldm_stm_seq;
   localparam int DW = 32;
   localparam int K_ST = 0, K_LD = 1, K_PC = 2, K_WB = 3, K_DONE = 4, K_BAD = 9;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [3:0]  rg;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ldm_stm_seq_if #(.DW(DW)) bus();
   ldm_stm_seq #(.DW(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] rf_seed = 32'hA0;
   int          ready_pct = 100;
   int          hold_cnt = 0;
   ev_t         exp_q[$];

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h0000_00C3;
   endfunction

   assign bus.mem_rdata = mem_fn(bus.mem_addr);
   assign bus.rf_rd     = rf_seed + {28'd0, bus.rf_ra};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: derive the whole transaction from the architectural rules.
   task automatic model_launch(input bit ld, input bit up, input bit pre, input bit wb,
                               input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
      int n = 0;
      int k = 0;
      logic [31:0] span, lo;
      ev_t e;
      for (int i = 0; i < 16; i++) n += int'(list[i]);
      span = 32'(n * 4);
      if (up) lo = pre ? base + 32'd4 : base;
      else    lo = pre ? base - span : base - span + 32'd4;
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            e.addr = lo + 32'(4 * k);
            e.rg   = 4'(i);
            if (!ld) begin
               e.kind = K_ST;
               e.data = rf_seed + 32'(i);
            end else begin
               e.kind = (i == 15) ? K_PC : K_LD;
               e.data = mem_fn(e.addr);
            end
            exp_q.push_back(e);
            k++;
         end
      end
      if (n > 0 && wb && !(ld && list[rn]) && rn != 4'd15) begin
         e.kind = K_WB; e.addr = 32'd0; e.rg = rn;
         e.data = up ? base + span : base - span;
         exp_q.push_back(e);
      end
      e.kind = K_DONE; e.addr = 32'd0; e.rg = 4'd0; e.data = 32'd0;
      exp_q.push_back(e);
   endtask

   // Memory handshake driver: optional forced wait at the first access, else random readiness.
   always @(posedge clk) begin
      #1;
      if (hold_cnt > 0 && bus.mem_req) begin
         bus.mem_ready = 1'b0;
         hold_cnt--;
      end else begin
         bus.mem_ready = (int'($urandom_range(0, 99)) < ready_pct);
      end
   end

   ev_t         mon_act, mon_exp;
   bit          mon_have;
   bit          prev_wait = 1'b0;
   logic [31:0] prev_addr;
   logic        prev_we;

   // Monitor: classify what the DUT presents this cycle and compare with the queue head.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.rf_we || bus.pc_write) chk("we_pc_exclusive", 64'(bus.rf_we & bus.pc_write), 64'd0);
         if (bus.rf_we) chk("rf_wa_not_pc", 64'(bus.rf_wa == 4'd15), 64'd0);
         if (bus.mem_req && !bus.mem_ready) begin
            if (prev_wait) begin
               chk("wait_addr_stable", 64'(bus.mem_addr), 64'(prev_addr));
               chk("wait_we_stable", 64'(bus.mem_we), 64'(prev_we));
            end
            chk("wait_no_rf_write", 64'({bus.rf_we, bus.pc_write}), 64'd0);
            prev_wait = 1'b1;
            prev_addr = bus.mem_addr;
            prev_we   = bus.mem_we;
         end else begin
            prev_wait = 1'b0;
         end
         mon_have = 1'b1;
         mon_act.addr = 32'd0; mon_act.rg = 4'd0; mon_act.data = 32'd0;
         if (bus.mem_req && bus.mem_ready) begin
            mon_act.addr = bus.mem_addr;
            if (bus.mem_we) begin
               mon_act.kind = K_ST; mon_act.rg = bus.rf_ra; mon_act.data = bus.mem_wdata;
               chk("store_no_rf_we", 64'(bus.rf_we), 64'd0);
            end else if (bus.pc_write) begin
               mon_act.kind = K_PC; mon_act.rg = 4'd15; mon_act.data = bus.rf_wd;
            end else if (bus.rf_we) begin
               mon_act.kind = K_LD; mon_act.rg = bus.rf_wa; mon_act.data = bus.rf_wd;
            end else begin
               mon_act.kind = K_BAD;
            end
         end else if (bus.rf_we) begin
            mon_act.kind = K_WB; mon_act.rg = bus.rf_wa; mon_act.data = bus.rf_wd;
         end else if (bus.done) begin
            mon_act.kind = K_DONE;
         end else begin
            mon_have = 1'b0;
         end
         if (mon_have) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event_kind", 64'(mon_act.kind), 64'hFFFF);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("event_kind", 64'(mon_act.kind), 64'(mon_exp.kind));
               chk("event_addr", 64'(mon_act.addr), 64'(mon_exp.addr));
               chk("event_reg", 64'(mon_act.rg), 64'(mon_exp.rg));
               chk("event_data", 64'(mon_act.data), 64'(mon_exp.data));
            end
         end
      end else begin
         prev_wait = 1'b0;
      end
   end

   task automatic check_all_zero(input string name);
      chk({name, "_ctl"}, 64'({bus.busy, bus.done, bus.mem_req, bus.mem_we, bus.rf_we, bus.pc_write}), 64'd0);
      chk({name, "_addr"}, 64'(bus.mem_addr), 64'd0);
      chk({name, "_ra_wa"}, 64'({bus.rf_ra, bus.rf_wa}), 64'd0);
      chk({name, "_wd"}, 64'(bus.rf_wd), 64'd0);
   endtask

   task automatic set_cmd(input bit ld, input bit up, input bit pre, input bit wb,
                          input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base);
      bus.load = ld; bus.up = up; bus.pre = pre; bus.wback = wb;
      bus.rn = rn; bus.reglist = list; bus.base = base;
   endtask

   // Launch from IDLE and wait (bounded) for done; exp_cycles > 0 also checks latency and busy span.
   task automatic run_op(input bit ld, input bit up, input bit pre, input bit wb,
                         input logic [3:0] rn, input logic [15:0] list, input logic [31:0] base,
                         input int exp_cycles, input bit noise);
      int cyc, busy_cnt;
      set_cmd(ld, up, pre, wb, rn, list, base);
      bus.start = 1'b1;
      model_launch(ld, up, pre, wb, rn, list, base);
      @(posedge clk); #1;
      cyc = 1; busy_cnt = 0;
      bus.start = noise;
      while (!bus.done && cyc < 400) begin
         busy_cnt += int'(bus.busy);
         if (noise) set_cmd($urandom, $urandom, $urandom, $urandom, 4'($urandom), 16'($urandom), $urandom);
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      if (!bus.done) begin
         chk("done_timeout", 64'(cyc), 64'(exp_cycles));
      end else begin
         busy_cnt += int'(bus.busy);
         if (exp_cycles > 0) begin
            chk("done_latency", 64'(cyc), 64'(exp_cycles));
            chk("busy_cycles", 64'(busy_cnt), 64'(exp_cycles));
         end
         @(posedge clk); #1;
         chk("idle_after_done", 64'({bus.busy, bus.done}), 64'd0);
      end
   endtask

   initial begin
      int n;
      bit ld, wb;
      logic [15:0] list;
      bus.start = 1'b0;
      set_cmd(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset_n = 1'b1;
      @(posedge clk); #1;

      // LDMIA base 0x100, R0/R1/R3 with writeback of 0x10C; done 5 cycles after start
      run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 16'h000B, 32'h100, 5, 1'b0);
      // STMDB base 0x200, R4 and LR, no writeback
      rf_seed = 32'hA0;
      run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 16'h4010, 32'h200, 3, 1'b0);
      // LDMIB with R15, three wait states on the first access
      hold_cnt = 3;
      run_op(1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 16'h8001, 32'h40, 6, 1'b0);
      // LDMIA with base in list: writeback suppressed
      run_op(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0004, 32'h300, 3, 1'b0);
      // empty list: single busy cycle, done the cycle after start
      run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd3, 16'h0000, 32'h500, 1, 1'b0);
      // STM with base in list stores original base value, then writes back
      run_op(1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 16'h0030, 32'hFFFF_FFF8, 4, 1'b0);

      // Reset during the second transfer of a 4-register LDM
      set_cmd(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h00F0, 32'h600);
      bus.start = 1'b1;
      model_launch(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 16'h00F0, 32'h600);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      exp_q.delete();
      #1;
      check_all_zero("abort");
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_abort_idle", 64'({bus.mem_req, bus.rf_we, bus.busy}), 64'd0);
      end
      @(posedge clk); #1;
      run_op(1'b1, 1'b0, 1'b0, 1'b1, 4'd9, 16'h00F0, 32'h700, 6, 1'b0);

      // Randomized transfers with random readiness and start noise while busy
      for (int t = 0; t < 40; t++) begin
         ready_pct = (t % 3 == 0) ? 100 : int'($urandom_range(30, 100));
         rf_seed = $urandom;
         ld = $urandom;
         wb = $urandom;
         case (t % 5)
            0:       list = 16'h0000;
            1:       list = 16'hFFFF;
            default: list = 16'($urandom);
         endcase
         n = 0;
         for (int i = 0; i < 16; i++) n += int'(list[i]);
         run_op(ld, $urandom, $urandom, wb, 4'($urandom), list, $urandom,
                (ready_pct == 100) ? ((n == 0) ? 1 : n + int'(wb) + 1) : 0, $urandom);
      end

      repeat (3) @(posedge clk);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Multi-cycle block-transfer sequencer for the pipelined ARM core. It executes LDM/STM, and it is the initiator side of the register-file port protocol.
- Walks a 16-bit register list and issues one memory access per register.
- Drives register-file read addresses for stores and write addresses/enables for loads.
- Performs the optional base writeback. The pipeline holds the rest of the core stalled while busy=1.

Parameters:
- DW, 32, data and address width in bits. Word stride is DW/8 bytes.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  launch request; sampled only in IDLE
- load  in  1  1 = LDM, 0 = STM
- up  in  1  U bit: 1 = increment, 0 = decrement
- pre  in  1  P bit: 1 = before, 0 = after
- wback  in  1  W bit: write updated base to rn
- rn  in  4  base register number
- reglist  in  16  register list; bit i = Ri
- base  in  DW  value of rn at launch
- busy  out  1  high from the cycle after launch until DONE exits
- done  out  1  one-cycle completion pulse
- mem_req  out  1  memory access valid
- mem_we  out  1  1 = write (STM)
- mem_addr  out  DW  word address of current access
- mem_wdata  out  DW  store data (= rf_rd)
- mem_rdata  in  DW  load data; valid when mem_ready=1
- mem_ready  in  1  access completes this cycle
- rf_ra  out  4  register-file read address (STM source)
- rf_rd  in  DW  register-file read data (combinational return)
- rf_wa  out  4  register-file write address
- rf_we  out  1  register-file write enable
- rf_wd  out  DW  register-file write data
- pc_write  out  1  load targets R15; redirect PC with rf_wd

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE. All registers are cleared.
  - Every output is 0: busy, done, mem_req, mem_we, mem_addr, rf_ra, rf_wa, rf_we, rf_wd, pc_write.
  - Reset asserted mid-transfer aborts immediately. No further writes occur.
- States: IDLE, XFER, WB, DONE.
- IDLE:
  - When start=1, latch load, up, wback, rn and reglist into pend.
  - Compute n = popcount(reglist).
  - Compute the start address:
    - IA (U=1, P=0): base
    - IB (U=1, P=1): base+4
    - DA (U=0, P=0): base-4n+4
    - DB (U=0, P=1): base-4n
  - Latch newbase = up ? base+4n : base-4n. All arithmetic is modulo 2^DW.
  - If n=0, go to DONE: no access and no writeback. Otherwise go to XFER.
- XFER:
  - cur = lowest set bit of pend. Transfers always run in ascending register order at ascending addresses.
  - mem_req=1, mem_we=!load, mem_addr=addr.
  - For STM: rf_ra=cur and mem_wdata=rf_rd.
  - mem_req, mem_we and mem_addr are derived from registered state only, with no combinational path from inputs.
  - mem_ready=0 holds all outputs stable (wait state, unbounded).
  - When mem_ready=1:
    - Load with cur≠15: rf_we=1, rf_wa=cur, rf_wd=mem_rdata, all in the same cycle.
    - Load with cur=15: rf_we=0, pc_write=1, rf_wd=mem_rdata.
    - Then clear bit cur in pend and set addr+=4.
    - If pend becomes empty, go to WB when wback=1, otherwise to DONE.
- WB:
  - Lasts one cycle: rf_we=1, rf_wa=rn, rf_wd=newbase.
  - This is a separate cycle because the register file has a single write port.
  - Writeback is suppressed (rf_we=0) when load=1 and rn is in the latched list; the loaded value wins.
  - For STM with rn in the list, the stored value is the original base, since writeback happens after all stores.
  - Next state: DONE.
- DONE:
  - done=1 for one cycle, then return to IDLE.
  - start is accepted again in the IDLE cycle that follows; there is no back-to-back launch in the same cycle as DONE.
- busy=1 in XFER, WB and DONE. start is ignored while busy.
- rf_we and pc_write are never both 1. rf_wa is never 15 while rf_we=1.

Test Plan:
- LDMIA, base=0x100, reglist=0x000B, wback=1, mem_ready=1 every cycle:
  - Accesses at 0x100, 0x104, 0x108 write R0, R1, R3.
  - WB writes rn=0x10C.
  - done pulses 5 cycles after start.
- STMDB, base=0x200, reglist=0x4010 (R4, LR), rf_rd=0xA0+ra:
  - mem writes 0x1F8←0xA4 and 0x1FC←0xAE.
  - mem_we=1; no rf_we when wback=0.
- LDMIB with R15 in the list, base=0x40, reglist=0x8001, mem_ready held low 3 cycles on the first access:
  - Outputs stay stable during the wait.
  - R0←[0x44]; pc_write=1 with rf_wd=[0x48]; rf_we=0 on that cycle.
- LDMIA, rn=2, reglist=0x0004, wback=1:
  - R2←mem.
  - No WB write (rf_we=0 in WB); done follows.
- reglist=0x0000:
  - No mem_req; done pulses the cycle after start; busy high for exactly 1 cycle.
- reset_n pulsed low during the 2nd transfer of a 4-register LDM:
  - All outputs go to 0 immediately, the state returns to IDLE, and no further rf_we occurs.
  - A new start after release runs normally.
